// File: rtl/hazard_ctrl_multi.sv
// Load-use hazard controller with multi-cycle stall support.
// Freezes PC/IF-ID and bubbles ID/EX for LOAD_LAT cycles per hazard.
module hazard_ctrl_multi #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   id_instr,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              branch_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic              bubble_idex,
    output logic              flush_ifid,
    output logic              hazard_busy,
    output logic [CNT_W-1:0]  stall_count
);

    // Remaining-cycle counter holds at most LOAD_LAT-1.
    localparam int REM_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [REM_W-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [6:0]         opcode;
    logic [4:0]         rs1, rs2;
    logic               use_rs1, use_rs2;
    logic               hit;
    logic               unused_instr;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // Fields outside opcode/rs1/rs2 play no part in detection.
    assign unused_instr = ^{id_instr[XLEN-1:25], id_instr[14:7]};

    // Decide which source fields the ID instruction actually reads.
    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        unique case (opcode)
            7'b0110111, 7'b0010111, 7'b1101111: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b0;
            end
            7'b0110011, 7'b0100011, 7'b1100011: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
        endcase
    end

    // A load into x0 never creates a real dependency.
    assign hit = ex_mem_read
               & (ex_rd != '0)
               & ((use_rs1 & (ex_rd == REG_AW'(rs1)))
                | (use_rs2 & (ex_rd == REG_AW'(rs2))));

    // Next-state, remaining-count and same-cycle control outputs.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        hazard_busy = (state_q == STALL);
        if (branch_taken) begin
            flush_ifid  = 1'b1;
            bubble_idex = 1'b1;
            state_d     = IDLE;
            rem_d       = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        stall_pc    = 1'b1;
                        stall_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                STALL: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                    if (rem_q == REM_ONE) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - REM_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    rem_d   = '0;
                end
            endcase
        end
        // Keep the pipeline untouched while reset is held.
        if (rst) begin
            stall_pc    = 1'b0;
            stall_ifid  = 1'b0;
            bubble_idex = 1'b0;
            flush_ifid  = 1'b0;
            hazard_busy = 1'b0;
        end
    end

    // Saturating count of PC-stall cycles.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_pc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign stall_count = cnt_q;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
// Directed bench for hazard_ctrl_multi: a LOAD_LAT=1/CNT_W=2
// instance for the decode table, a LOAD_LAT=3 one for sequences.
module tb_hazard_ctrl_multi;

    logic clk;
    logic rst;

    logic [31:0] a_instr;
    logic [4:0]  a_rd;
    logic        a_mr, a_br;
    logic        a_spc, a_sif, a_bub, a_fl, a_busy;
    logic [1:0]  a_cnt;

    logic [31:0] b_instr;
    logic [4:0]  b_rd;
    logic        b_mr, b_br;
    logic        b_spc, b_sif, b_bub, b_fl, b_busy;
    logic [15:0] b_cnt;

    int n_vec;
    int n_err;

    hazard_ctrl_multi #(
        .XLEN(32), .REG_AW(5), .LOAD_LAT(1), .CNT_W(2)
    ) dut_a (
        .clk(clk), .rst(rst),
        .id_instr(a_instr), .ex_rd(a_rd),
        .ex_mem_read(a_mr), .branch_taken(a_br),
        .stall_pc(a_spc), .stall_ifid(a_sif),
        .bubble_idex(a_bub), .flush_ifid(a_fl),
        .hazard_busy(a_busy), .stall_count(a_cnt)
    );

    hazard_ctrl_multi #(
        .XLEN(32), .REG_AW(5), .LOAD_LAT(3), .CNT_W(16)
    ) dut_b (
        .clk(clk), .rst(rst),
        .id_instr(b_instr), .ex_rd(b_rd),
        .ex_mem_read(b_mr), .branch_taken(b_br),
        .stall_pc(b_spc), .stall_ifid(b_sif),
        .bubble_idex(b_bub), .flush_ifid(b_fl),
        .hazard_busy(b_busy), .stall_count(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {stall_pc, stall_ifid, bubble_idex, flush_ifid, hazard_busy}
    function automatic logic [4:0] outs_a();
        return {a_spc, a_sif, a_bub, a_fl, a_busy};
    endfunction

    function automatic logic [4:0] outs_b();
        return {b_spc, b_sif, b_bub, b_fl, b_busy};
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op,
                                        input logic [4:0] r1,
                                        input logic [4:0] r2);
        return {7'b0, r2, r1, 3'b000, 5'd7, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic        mr;
        logic        br;
        logic [4:0]  exp;
    } vec_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [6:0] OP_FNC = 7'b0001111;

    localparam logic [4:0] STL = 5'b11100;
    localparam logic [4:0] NON = 5'b00000;
    localparam logic [4:0] FLS = 5'b00110;

    vec_t tbl[18];
    logic [31:0] add_dep;

    initial begin
        n_vec = 0;
        n_err = 0;
        add_dep = enc(OP_R, 5'd5, 5'd6);

        tbl[0]  = '{add_dep,                 5'd5, 1'b1, 1'b0, STL};
        tbl[1]  = '{add_dep,                 5'd6, 1'b1, 1'b0, STL};
        tbl[2]  = '{add_dep,                 5'd5, 1'b0, 1'b0, NON};
        tbl[3]  = '{enc(OP_R, 5'd0, 5'd6),   5'd0, 1'b1, 1'b0, NON};
        tbl[4]  = '{enc(OP_LUI, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0, NON};
        tbl[5]  = '{enc(OP_I, 5'd1, 5'd5),   5'd5, 1'b1, 1'b0, NON};
        tbl[6]  = '{enc(OP_I, 5'd5, 5'd1),   5'd5, 1'b1, 1'b0, STL};
        tbl[7]  = '{enc(OP_LD, 5'd5, 5'd1),  5'd5, 1'b1, 1'b0, STL};
        tbl[8]  = '{enc(OP_ST, 5'd1, 5'd5),  5'd5, 1'b1, 1'b0, STL};
        tbl[9]  = '{enc(OP_BR, 5'd1, 5'd5),  5'd5, 1'b1, 1'b0, STL};
        tbl[10] = '{enc(OP_JAL, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0, NON};
        tbl[11] = '{enc(OP_AUI, 5'd5, 5'd5), 5'd5, 1'b1, 1'b0, NON};
        tbl[12] = '{enc(OP_JR, 5'd1, 5'd5),  5'd5, 1'b1, 1'b0, NON};
        tbl[13] = '{enc(OP_SYS, 5'd5, 5'd1), 5'd5, 1'b1, 1'b0, STL};
        tbl[14] = '{enc(OP_FNC, 5'd1, 5'd5), 5'd5, 1'b1, 1'b0, STL};
        tbl[15] = '{add_dep,                 5'd5, 1'b1, 1'b1, FLS};
        tbl[16] = '{add_dep,                 5'd9, 1'b0, 1'b1, FLS};
        tbl[17] = '{add_dep,                 5'd3, 1'b1, 1'b0, NON};

        // Reset state, with a live hazard on both inputs.
        rst = 1'b1;
        a_instr = add_dep; a_rd = 5'd5; a_mr = 1'b1; a_br = 1'b0;
        b_instr = add_dep; b_rd = 5'd5; b_mr = 1'b1; b_br = 1'b0;
        #1;
        chk("rst_outs_a", 32'(outs_a()), 32'(NON));
        chk("rst_outs_b", 32'(outs_b()), 32'(NON));
        chk("rst_cnt_a", 32'(a_cnt), 32'd0);
        chk("rst_cnt_b", 32'(b_cnt), 32'd0);
        a_mr = 1'b0; b_mr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Decode / hit table on the single-cycle instance.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            a_instr = tbl[i].instr;
            a_rd    = tbl[i].rd;
            a_mr    = tbl[i].mr;
            a_br    = tbl[i].br;
            #1;
            chk($sformatf("tbl[%0d]", i), 32'(outs_a()), 32'(tbl[i].exp));
        end

        // Saturating counter: five isolated single-cycle stalls.
        @(negedge clk);
        a_mr = 1'b0; a_br = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            a_instr = add_dep; a_rd = 5'd5; a_mr = 1'b1;
            @(negedge clk);
            a_mr = 1'b0;
            #1;
            chk($sformatf("sat_cnt[%0d]", k), 32'(a_cnt),
                (k < 3) ? k + 1 : 3);
        end

        // Three-cycle stall, then a fresh back-to-back hazard.
        @(negedge clk);
        b_instr = add_dep; b_rd = 5'd5; b_mr = 1'b1; b_br = 1'b0;
        #1;
        chk("lat3_c1", 32'(outs_b()), 32'(STL));
        @(negedge clk); #1;
        chk("lat3_c2", 32'(outs_b()), 32'(5'b11101));
        @(negedge clk); #1;
        chk("lat3_c3", 32'(outs_b()), 32'(5'b11101));
        chk("lat3_cnt", 32'(b_cnt), 32'd2);
        @(negedge clk); #1;
        chk("b2b_c1", 32'(outs_b()), 32'(STL));
        chk("b2b_cnt", 32'(b_cnt), 32'd3);

        // Taken branch in the second stall cycle wins.
        @(negedge clk);
        b_br = 1'b1;
        #1;
        chk("br_in_stall", 32'(outs_b()), 32'(5'b00111));
        @(negedge clk);
        b_br = 1'b0; b_mr = 1'b0;
        #1;
        chk("br_after", 32'(outs_b()), 32'(NON));
        chk("br_cnt", 32'(b_cnt), 32'd4);

        // Asynchronous reset in the middle of a stall.
        @(negedge clk);
        b_mr = 1'b1;
        @(negedge clk); #1;
        chk("pre_rst_busy", 32'(outs_b()), 32'(5'b11101));
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'(outs_b()), 32'(NON));
        chk("mid_rst_cnt", 32'(b_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        b_mr = 1'b0;
        #1;
        chk("post_rst_idle", 32'(outs_b()), 32'(NON));
        @(negedge clk); #1;
        chk("post_rst_cnt", 32'(b_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
